// File: rtl/hazard_ctrl_if.sv
// Decode-side hazard/forwarding bus: decode instruction fields toward the
// hazard controller, bypass selects and load-use stall back to decode/fetch.
interface hazard_ctrl_if #(
  parameter int REG_NUM   = 32,
  parameter int CNT_WIDTH = 32
);
  localparam int AW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  // decode instruction fields
  logic          i_dec_valid;
  logic [AW-1:0] i_rs1_addr;
  logic [AW-1:0] i_rs2_addr;
  logic [AW-1:0] i_rd_addr;
  logic          i_valid_rs1;
  logic          i_valid_rs2;
  logic          i_rf_wr_en;
  logic          i_is_load;
  logic          i_flush;
  logic          i_hold;

  // forwarding selects, stall and performance counter
  logic                 o_bypass_from_exe_valid_rs1;
  logic                 o_bypass_from_exe_valid_rs2;
  logic                 o_bypass_from_mem_valid_rs1;
  logic                 o_bypass_from_mem_valid_rs2;
  logic                 o_bypass_from_wb_valid_rs1;
  logic                 o_bypass_from_wb_valid_rs2;
  logic                 o_stall;
  logic [CNT_WIDTH-1:0] o_stall_cnt;

  // pipeline side: drives decode fields, consumes selects
  modport master (
    output i_dec_valid, i_rs1_addr, i_rs2_addr, i_rd_addr,
           i_valid_rs1, i_valid_rs2, i_rf_wr_en, i_is_load,
           i_flush, i_hold,
    input  o_bypass_from_exe_valid_rs1, o_bypass_from_exe_valid_rs2,
           o_bypass_from_mem_valid_rs1, o_bypass_from_mem_valid_rs2,
           o_bypass_from_wb_valid_rs1,  o_bypass_from_wb_valid_rs2,
           o_stall, o_stall_cnt
  );

  // hazard controller side
  modport slave (
    input  i_dec_valid, i_rs1_addr, i_rs2_addr, i_rd_addr,
           i_valid_rs1, i_valid_rs2, i_rf_wr_en, i_is_load,
           i_flush, i_hold,
    output o_bypass_from_exe_valid_rs1, o_bypass_from_exe_valid_rs2,
           o_bypass_from_mem_valid_rs1, o_bypass_from_mem_valid_rs2,
           o_bypass_from_wb_valid_rs1,  o_bypass_from_wb_valid_rs2,
           o_stall, o_stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the in-order 5-stage RV32I pipeline.
// Tracks rd/write-enable/load shadows of EXE, MEM and WB, produces one-hot
// per-operand bypass selects (EXE > MEM > WB), the load-use stall and a
// saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int REG_NUM   = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  hazard_ctrl_if.slave  hz
);
  localparam int AW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  // shadow scoreboard
  logic          ex_v, ex_we, ex_ld;
  logic [AW-1:0] ex_rd;
  logic          mem_v, mem_we;
  logic [AW-1:0] mem_rd;
  logic          wb_v, wb_we;
  logic [AW-1:0] wb_rd;

  logic [CNT_WIDTH-1:0] stall_cnt;

  // operand hit flags per stage
  logic match_ex_rs1, match_ex_rs2;
  logic match_mem_rs1, match_mem_rs2;
  logic match_wb_rs1, match_wb_rs2;
  logic hazard, stall, ex_accept;

  // compare decode operands against each producing stage; x0 never hits
  always_comb begin
    match_ex_rs1  = ex_v  & ex_we  & (ex_rd  != '0) & (ex_rd  == hz.i_rs1_addr)
                    & hz.i_valid_rs1 & hz.i_dec_valid;
    match_ex_rs2  = ex_v  & ex_we  & (ex_rd  != '0) & (ex_rd  == hz.i_rs2_addr)
                    & hz.i_valid_rs2 & hz.i_dec_valid;
    match_mem_rs1 = mem_v & mem_we & (mem_rd != '0) & (mem_rd == hz.i_rs1_addr)
                    & hz.i_valid_rs1 & hz.i_dec_valid;
    match_mem_rs2 = mem_v & mem_we & (mem_rd != '0) & (mem_rd == hz.i_rs2_addr)
                    & hz.i_valid_rs2 & hz.i_dec_valid;
    match_wb_rs1  = wb_v  & wb_we  & (wb_rd  != '0) & (wb_rd  == hz.i_rs1_addr)
                    & hz.i_valid_rs1 & hz.i_dec_valid;
    match_wb_rs2  = wb_v  & wb_we  & (wb_rd  != '0) & (wb_rd  == hz.i_rs2_addr)
                    & hz.i_valid_rs2 & hz.i_dec_valid;
  end

  // load-use detection; a flush kills the consumer so it never stalls
  always_comb begin
    hazard    = ex_ld & (match_ex_rs1 | match_ex_rs2);
    stall     = hazard & ~hz.i_flush;
    ex_accept = hz.i_dec_valid & ~stall & ~hz.i_flush;
  end

  // priority-encoded bypass selects; a load in EXE has no data to forward,
  // which also clears every select of the hazarded operand during a stall
  always_comb begin
    hz.o_bypass_from_exe_valid_rs1 = match_ex_rs1 & ~ex_ld;
    hz.o_bypass_from_exe_valid_rs2 = match_ex_rs2 & ~ex_ld;
    hz.o_bypass_from_mem_valid_rs1 = match_mem_rs1 & ~match_ex_rs1;
    hz.o_bypass_from_mem_valid_rs2 = match_mem_rs2 & ~match_ex_rs2;
    hz.o_bypass_from_wb_valid_rs1  = match_wb_rs1 & ~match_ex_rs1 & ~match_mem_rs1;
    hz.o_bypass_from_wb_valid_rs2  = match_wb_rs2 & ~match_ex_rs2 & ~match_mem_rs2;
    hz.o_stall                     = stall;
    hz.o_stall_cnt                 = stall_cnt;
  end

  // EXE shadow: capture the decode instruction or insert a bubble
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_v  <= 1'b0;
      ex_rd <= '0;
      ex_we <= 1'b0;
      ex_ld <= 1'b0;
    end else if (!hz.i_hold) begin
      if (ex_accept) begin
        ex_v  <= hz.i_dec_valid;
        ex_rd <= hz.i_rd_addr;
        ex_we <= hz.i_rf_wr_en;
        ex_ld <= hz.i_is_load;
      end else begin
        ex_v  <= 1'b0;
        ex_rd <= '0;
        ex_we <= 1'b0;
        ex_ld <= 1'b0;
      end
    end
  end

  // MEM and WB shadows follow the pipeline
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_v  <= 1'b0;
      mem_rd <= '0;
      mem_we <= 1'b0;
      wb_v   <= 1'b0;
      wb_rd  <= '0;
      wb_we  <= 1'b0;
    end else if (!hz.i_hold) begin
      mem_v  <= ex_v;
      mem_rd <= ex_rd;
      mem_we <= ex_we;
      wb_v   <= mem_v;
      wb_rd  <= mem_rd;
      wb_we  <= mem_we;
    end
  end

  // saturating load-use stall cycle counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt <= '0;
    end else if (!hz.i_hold && stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the in-order 5-stage RV32I pipeline.
- Keeps a shadow scoreboard (rd, write enable, load flag) of the instructions in EXE, MEM and WB.
- Drives the six bypass-select valids consumed by the decode stage, plus the load-use stall toward fetch/decode.
- Inserts bubbles into the EXE shadow on stall/flush and counts stall cycles for performance monitoring.

Parameters:
REG_NUM, 32, number of architectural registers; address width is $clog2(REG_NUM)
CNT_WIDTH, 32, width of stall-cycle counter

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_dec_valid  input  1  decode holds a valid instruction
i_rs1_addr  input  $clog2(REG_NUM)  decode rs1 address
i_rs2_addr  input  $clog2(REG_NUM)  decode rs2 address
i_rd_addr  input  $clog2(REG_NUM)  decode rd address
i_valid_rs1  input  1  decode instruction reads rs1
i_valid_rs2  input  1  decode instruction reads rs2
i_rf_wr_en  input  1  decode instruction writes rd
i_is_load  input  1  decode instruction is a load
i_flush  input  1  taken branch/jump resolved in EXE; kill decode instruction
i_hold  input  1  global pipeline freeze (memory wait); all stages stall
o_bypass_from_exe_valid_rs1  output  1  forward EXE result to rs1
o_bypass_from_exe_valid_rs2  output  1  forward EXE result to rs2
o_bypass_from_mem_valid_rs1  output  1  forward MEM result to rs1
o_bypass_from_mem_valid_rs2  output  1  forward MEM result to rs2
o_bypass_from_wb_valid_rs1  output  1  forward WB result to rs1
o_bypass_from_wb_valid_rs2  output  1  forward WB result to rs2
o_stall  output  1  load-use stall: hold PC and decode register
o_stall_cnt  output  CNT_WIDTH  saturating count of load-use stall cycles

Behaviour:
- Shadow regs per stage S in {ex, mem, wb}: S_v, S_rd, S_we. ex also has ex_ld. All reset to 0.
- Reset values: o_stall_cnt = 0. All combinational outputs are 0, since every shadow valid is 0 at reset.
- Hit condition: matchS_rsN = S_v & S_we & (S_rd != 0) & (S_rd == i_rsN_addr) & i_valid_rsN & i_dec_valid. Register x0 never hits.
- Load-use hazard:
  - hazard = ex_ld & (matchEX_rs1 | matchEX_rs2).
  - o_stall = hazard & ~i_flush. Combinational, same cycle.
- Bypass outputs are one-hot per operand, priority EXE > MEM > WB:
  - exe_valid_rsN = matchEX_rsN & ~ex_ld. A load's data is not ready in EXE.
  - mem_valid_rsN = matchMEM_rsN & ~matchEX_rsN.
  - wb_valid_rsN = matchWB_rsN & ~matchEX_rsN & ~matchMEM_rsN.
  - During o_stall, all bypass outputs for the hazarded operand are 0.
- Advance on the rising edge when i_hold = 0:
  - wb <= mem; mem <= ex.
  - ex <= {i_dec_valid, i_rd_addr, i_rf_wr_en, i_is_load} if i_dec_valid & ~o_stall & ~i_flush; otherwise ex <= bubble (ex_v = 0, ex_we = 0, ex_ld = 0).
- i_hold = 1: all shadow regs and the counter are frozen. Outputs stay combinationally valid against the frozen state.
- Simultaneous events:
  - i_flush & hazard: flush wins. o_stall = 0 and EXE gets a bubble.
  - i_hold & o_stall: o_stall still asserted; no state change.
- Stall resolution latency: exactly 1 cycle after the load enters EXE. The next edge moves the load to MEM; the following cycle asserts mem_valid for the operand.
- Counter: +1 on each edge with o_stall & ~i_hold. Saturates at all-ones and does not wrap.
- Reset asserted mid-operation: shadow regs clear asynchronously; outputs drop to 0 immediately with no pending hazard retained.

Test Plan:
- Back-to-back ALU RAW: `add x5,x1,x2` then `sub x6,x5,x3` -> cycle 2: exe_valid_rs1=1, o_stall=0; all other bypass valids 0.
- Load-use: `lw x7,0(x1)` then `add x8,x7,x7`:
  - cycle 2: o_stall=1, all rs1/rs2 bypass valids 0.
  - cycle 3: o_stall=0, mem_valid_rs1=mem_valid_rs2=1.
  - o_stall_cnt=1.
- Priority: writes to x4 in WB, MEM and EXE, then a reader of x4 -> only exe_valid_rs1=1. Drop the EXE writer -> only mem_valid_rs1=1.
- x0 and invalid-operand filtering:
  - writer `addi x0,x0,1` followed by reader of x0 -> all bypass valids 0.
  - `lui x9` (i_valid_rs1=0, rs1 field=9) after a writer of x9 -> no bypass.
- Flush/hold interaction:
  - load-use pair with i_flush=1 in the hazard cycle -> o_stall=0, ex_v=0 next cycle, counter unchanged.
  - i_hold=1 for 3 cycles during a stall -> o_stall stays 1, counter unchanged, state frozen.
- Reset and saturation:
  - i_rst_n low mid-stall -> o_stall=0 asynchronously, o_stall_cnt=0.
  - with CNT_WIDTH=4, 20 stall cycles -> o_stall_cnt=15.
